ccu_op_sequencer: RTL and testbench
===================================

CCU_OP_SEQUENCER -- requirements
Module: ccu_op_sequencer

Interface
REQ-001 SHALL expose parameter TMR_WIDTH, default 32, width of every counter, timer and progress output.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 operation_start  in  1  start bit from control register file.
REQ-005 data_loaded, grid_loaded, scle_loaded, wght_loaded  in  1 each  operand-ready flags.
REQ-006 rslt_size  in  32  total result beats per operation.
REQ-007 interrupt_soft, interrupt_abort, interrupt_error  in  1 each  PS interrupt requests.
REQ-008 rslt_tvalid, rslt_tready, rslt_tlast  in  1 each  monitored result AXI-Stream handshake.
REQ-009 core_start  out  1  one-cycle datapath start pulse.
REQ-010 core_rst  out  1  one-cycle datapath reset pulse.
REQ-011 rw_op_str_reg_en, operation_start_wr  out  1 each  start-bit write-back strobe and value.
REQ-012 rw_op_dne_reg_en, operation_done_wr  out  1 each  done-bit write-back strobe and value.
REQ-013 wo_reg_en, wo_reg_rst  out  1 each  write-only register update / clear strobes.
REQ-014 sts_idle, sts_busy, sts_error, sts_locked, sts_valid, sts_reset  out  1 each  status bits.
REQ-015 progress_rslt, progress_iter, iter_timer, iter_latency, oper_timer, oper_latency  out  TMR_WIDTH each.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states SHALL be IDLE, START, RUN, DONE, ERR.
REQ-018 IDLE: start with all four loaded flags high and rslt_size!=0 -> START; start with any flag low or rslt_size==0 -> ERR.
REQ-019 START (one cycle): core_start=1, wo_reg_rst=1, rw_op_str_reg_en=1 with operation_start_wr=0, sts_valid cleared, all counters/timers cleared; -> RUN.
REQ-020 Beat = rslt_tvalid&rslt_tready in RUN; each beat SHALL increment progress_rslt.
REQ-021 Beat with rslt_tlast SHALL increment progress_iter, load iter_latency=iter_timer+1, restart iter_timer at 0, and pulse wo_reg_en next cycle.
REQ-022 In RUN, oper_timer and iter_timer SHALL increment each cycle, saturating at all-ones (no wrap).
REQ-023 Beat bringing progress_rslt to rslt_size with tlast high -> DONE; same beat without tlast -> ERR.
REQ-024 DONE (one cycle): rw_op_dne_reg_en=1, operation_done_wr=1, wo_reg_en=1, oper_latency=oper_timer, sts_valid set; -> IDLE.
REQ-025 interrupt_error in START/RUN -> ERR; interrupt_abort in START/RUN -> IDLE with core_rst=1; error has priority over abort, both over beat completion in the same cycle.
REQ-026 ERR: sts_error=sts_locked=1, operation_start ignored; interrupt_soft -> IDLE with core_rst=1 and sts_reset=1 for one cycle.
REQ-027 sts_idle=1 only in IDLE; sts_busy=1 in START and RUN; sts_valid sticky until next START.
REQ-028 Beats outside RUN SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, from any state including mid-RUN, within one cycle.
REQ-030 Reset values: sts_idle=1, sts_reset=1 during rst; all other outputs 0, counters/timers 0.

Verification
REQ-031 Loaded flags high, rslt_size=4, start; 4 beats, tlast on beats 2 and 4, one beat per cycle -> progress_rslt=4, progress_iter=2, iter_latency=2, DONE strobes once, sts_valid=1.
REQ-032 Start with wght_loaded=0 -> ERR, sts_error=sts_locked=1, no core_start; interrupt_soft -> IDLE, sts_reset one cycle.
REQ-033 rslt_size=3, beat 3 without tlast -> ERR, no rw_op_dne_reg_en.
REQ-034 interrupt_abort during RUN after 1 beat -> IDLE, core_rst=1, progress_rslt held at 1, sts_valid=0.
REQ-035 Simultaneous interrupt_error and interrupt_abort with final tlast beat -> ERR.
REQ-036 rst asserted mid-RUN -> all outputs at REQ-030 values next cycle; new start runs normally.

Source files
------------

// File: rtl/ccu_op_sequencer.sv
// rtl/ccu_op_sequencer.sv - CCU operation sequencer: start/done handshake, result progress counters and timers
module ccu_op_sequencer #(
    parameter int TMR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 operation_start,
    input  logic                 data_loaded,
    input  logic                 grid_loaded,
    input  logic                 scle_loaded,
    input  logic                 wght_loaded,
    input  logic [31:0]          rslt_size,
    input  logic                 interrupt_soft,
    input  logic                 interrupt_abort,
    input  logic                 interrupt_error,
    input  logic                 rslt_tvalid,
    input  logic                 rslt_tready,
    input  logic                 rslt_tlast,
    output logic                 core_start,
    output logic                 core_rst,
    output logic                 rw_op_str_reg_en,
    output logic                 operation_start_wr,
    output logic                 rw_op_dne_reg_en,
    output logic                 operation_done_wr,
    output logic                 wo_reg_en,
    output logic                 wo_reg_rst,
    output logic                 sts_idle,
    output logic                 sts_busy,
    output logic                 sts_error,
    output logic                 sts_locked,
    output logic                 sts_valid,
    output logic                 sts_reset,
    output logic [TMR_WIDTH-1:0] progress_rslt,
    output logic [TMR_WIDTH-1:0] progress_iter,
    output logic [TMR_WIDTH-1:0] iter_timer,
    output logic [TMR_WIDTH-1:0] iter_latency,
    output logic [TMR_WIDTH-1:0] oper_timer,
    output logic [TMR_WIDTH-1:0] oper_latency
);

    localparam int CW = (TMR_WIDTH > 32) ? TMR_WIDTH : 32;

    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ERR} state_t;
    state_t state;

    function automatic logic [TMR_WIDTH-1:0] sat_inc(input logic [TMR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                 all_loaded;
    logic                 beat;
    logic                 final_beat;
    logic [CW-1:0]        rslt_cnt_next;
    logic [TMR_WIDTH-1:0] oper_next;
    logic [TMR_WIDTH-1:0] iter_next;

    assign all_loaded    = data_loaded & grid_loaded & scle_loaded & wght_loaded;
    assign beat          = rslt_tvalid & rslt_tready;
    assign rslt_cnt_next = CW'(progress_rslt) + CW'(1);
    assign final_beat    = (rslt_cnt_next == CW'(rslt_size));
    assign oper_next     = sat_inc(oper_timer);
    assign iter_next     = sat_inc(iter_timer);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            core_start         <= 1'b0;
            core_rst           <= 1'b0;
            rw_op_str_reg_en   <= 1'b0;
            operation_start_wr <= 1'b0;
            rw_op_dne_reg_en   <= 1'b0;
            operation_done_wr  <= 1'b0;
            wo_reg_en          <= 1'b0;
            wo_reg_rst         <= 1'b0;
            sts_idle           <= 1'b1;
            sts_busy           <= 1'b0;
            sts_error          <= 1'b0;
            sts_locked         <= 1'b0;
            sts_valid          <= 1'b0;
            sts_reset          <= 1'b1;
            progress_rslt      <= '0;
            progress_iter      <= '0;
            iter_timer         <= '0;
            iter_latency       <= '0;
            oper_timer         <= '0;
            oper_latency       <= '0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            core_start         <= 1'b0;
            core_rst           <= 1'b0;
            rw_op_str_reg_en   <= 1'b0;
            operation_start_wr <= 1'b0;
            rw_op_dne_reg_en   <= 1'b0;
            operation_done_wr  <= 1'b0;
            wo_reg_en          <= 1'b0;
            wo_reg_rst         <= 1'b0;
            sts_reset          <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (operation_start) begin
                        sts_idle <= 1'b0;
                        if (all_loaded && rslt_size != 32'd0) begin
                            state            <= S_START;
                            core_start       <= 1'b1;
                            wo_reg_rst       <= 1'b1;
                            rw_op_str_reg_en <= 1'b1;
                            sts_busy         <= 1'b1;
                            sts_valid        <= 1'b0;
                            progress_rslt    <= '0;
                            progress_iter    <= '0;
                            iter_timer       <= '0;
                            iter_latency     <= '0;
                            oper_timer       <= '0;
                            oper_latency     <= '0;
                        end else begin
                            state      <= S_ERR;
                            sts_error  <= 1'b1;
                            sts_locked <= 1'b1;
                        end
                    end
                end

                S_START: begin
                    if (interrupt_error) begin
                        state      <= S_ERR;
                        sts_busy   <= 1'b0;
                        sts_error  <= 1'b1;
                        sts_locked <= 1'b1;
                    end else if (interrupt_abort) begin
                        state    <= S_IDLE;
                        sts_busy <= 1'b0;
                        sts_idle <= 1'b1;
                        core_rst <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    oper_timer <= oper_next;
                    iter_timer <= iter_next;
                    // error beats abort beats the result beat in the same cycle
                    if (interrupt_error) begin
                        state      <= S_ERR;
                        sts_busy   <= 1'b0;
                        sts_error  <= 1'b1;
                        sts_locked <= 1'b1;
                    end else if (interrupt_abort) begin
                        state    <= S_IDLE;
                        sts_busy <= 1'b0;
                        sts_idle <= 1'b1;
                        core_rst <= 1'b1;
                    end else if (beat) begin
                        progress_rslt <= progress_rslt + 1'b1;
                        if (rslt_tlast) begin
                            progress_iter <= progress_iter + 1'b1;
                            iter_latency  <= iter_next;
                            iter_timer    <= '0;
                            wo_reg_en     <= 1'b1;
                        end
                        if (final_beat) begin
                            sts_busy <= 1'b0;
                            if (rslt_tlast) begin
                                state             <= S_DONE;
                                rw_op_dne_reg_en  <= 1'b1;
                                operation_done_wr <= 1'b1;
                                oper_latency      <= oper_next;
                                sts_valid         <= 1'b1;
                            end else begin
                                state      <= S_ERR;
                                sts_error  <= 1'b1;
                                sts_locked <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    sts_idle <= 1'b1;
                end

                S_ERR: begin
                    if (interrupt_soft) begin
                        state      <= S_IDLE;
                        sts_error  <= 1'b0;
                        sts_locked <= 1'b0;
                        sts_idle   <= 1'b1;
                        core_rst   <= 1'b1;
                        sts_reset  <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    sts_idle <= 1'b1;
                    sts_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_op_sequencer.sv
// tb/tb_ccu_op_sequencer.sv - self-checking bench for ccu_op_sequencer
module tb_ccu_op_sequencer;

    localparam int TW  = 8;
    localparam int SAT = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          operation_start;
    logic          data_loaded, grid_loaded, scle_loaded, wght_loaded;
    logic [31:0]   rslt_size;
    logic          interrupt_soft, interrupt_abort, interrupt_error;
    logic          rslt_tvalid, rslt_tready, rslt_tlast;
    logic          core_start, core_rst, rw_op_str_reg_en, operation_start_wr;
    logic          rw_op_dne_reg_en, operation_done_wr, wo_reg_en, wo_reg_rst;
    logic          sts_idle, sts_busy, sts_error, sts_locked, sts_valid, sts_reset;
    logic [TW-1:0] progress_rslt, progress_iter, iter_timer, iter_latency, oper_timer, oper_latency;

    always #5 clk = ~clk;

    ccu_op_sequencer #(.TMR_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .operation_start(operation_start),
        .data_loaded(data_loaded), .grid_loaded(grid_loaded),
        .scle_loaded(scle_loaded), .wght_loaded(wght_loaded),
        .rslt_size(rslt_size), .interrupt_soft(interrupt_soft),
        .interrupt_abort(interrupt_abort), .interrupt_error(interrupt_error),
        .rslt_tvalid(rslt_tvalid), .rslt_tready(rslt_tready), .rslt_tlast(rslt_tlast),
        .core_start(core_start), .core_rst(core_rst),
        .rw_op_str_reg_en(rw_op_str_reg_en), .operation_start_wr(operation_start_wr),
        .rw_op_dne_reg_en(rw_op_dne_reg_en), .operation_done_wr(operation_done_wr),
        .wo_reg_en(wo_reg_en), .wo_reg_rst(wo_reg_rst),
        .sts_idle(sts_idle), .sts_busy(sts_busy), .sts_error(sts_error),
        .sts_locked(sts_locked), .sts_valid(sts_valid), .sts_reset(sts_reset),
        .progress_rslt(progress_rslt), .progress_iter(progress_iter),
        .iter_timer(iter_timer), .iter_latency(iter_latency),
        .oper_timer(oper_timer), .oper_latency(oper_latency)
    );

    int n_chk  = 0;
    int n_fail = 0;

    bit plan_beat[$];
    bit plan_last[$];

    typedef struct {
        bit d, g, s, w;
        int size;
        bit exp_start;
    } start_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ins;
        operation_start = 0; interrupt_soft = 0; interrupt_abort = 0; interrupt_error = 0;
        rslt_tvalid = 0; rslt_tready = 0; rslt_tlast = 0;
    endtask

    task automatic set_loaded(input bit d, input bit g, input bit s, input bit w);
        data_loaded = d; grid_loaded = g; scle_loaded = s; wght_loaded = w;
    endtask

    task automatic drive_beat(input bit b, input bit l);
        int r;
        rslt_tlast = l;
        if (b) begin
            rslt_tvalid = 1; rslt_tready = 1;
        end else begin
            r = $urandom_range(0, 2);
            rslt_tvalid = (r == 1);
            rslt_tready = (r == 2);
        end
    endtask

    // Starts an operation with all operands loaded; leaves DUT entering RUN
    task automatic start_op(input int size);
        set_loaded(1, 1, 1, 1);
        rslt_size = size;
        operation_start = 1;
        tick;
        chk("start.core_start", core_start, 1);
        chk("start.wo_reg_rst", wo_reg_rst, 1);
        chk("start.str_reg_en", rw_op_str_reg_en, 1);
        chk("start.start_wr", operation_start_wr, 0);
        chk("start.busy", sts_busy, 1);
        chk("start.valid", sts_valid, 0);
        chk("start.progress", progress_rslt, 0);
        operation_start = 0;
        tick;
        chk("run.core_start", core_start, 0);
    endtask

    task automatic recover_err;
        operation_start = 1;
        tick;
        chk("err.start_ignored", core_start, 0);
        chk("err.still_error", sts_error, 1);
        operation_start = 0;
        interrupt_soft = 1;
        tick;
        chk("soft.idle", sts_idle, 1);
        chk("soft.reset", sts_reset, 1);
        chk("soft.core_rst", core_rst, 1);
        chk("soft.error_clr", sts_error, 0);
        interrupt_soft = 0;
        tick;
        chk("soft.reset_pulse", sts_reset, 0);
        chk("soft.core_rst_pulse", core_rst, 0);
    endtask

    // Applies plan_beat/plan_last as RUN cycles; expectations come from cycle arithmetic
    task automatic run_plan(input int size);
        int  cnt = 0, iters = 0, prev_end = -1, ilat = 0, len;
        bit  last_done;
        len = plan_beat.size();
        start_op(size);
        for (int k = 0; k < len; k++) begin
            drive_beat(plan_beat[k], plan_last[k]);
            tick;
            if (plan_beat[k]) begin
                cnt++;
                if (plan_last[k]) begin
                    iters++;
                    ilat = sat(k - prev_end);
                    prev_end = k;
                end
            end
            chk("run.progress_rslt", progress_rslt, cnt);
            chk("run.progress_iter", progress_iter, iters);
            chk("run.iter_latency", iter_latency, ilat);
            chk("run.iter_timer", iter_timer, sat(k - prev_end));
            chk("run.oper_timer", oper_timer, sat(k + 1));
            chk("run.wo_reg_en", wo_reg_en, plan_beat[k] && plan_last[k]);
            if (k < len - 1) chk("run.busy", sts_busy, 1);
        end
        clear_ins;
        last_done = plan_last[len - 1];
        chk("end.busy", sts_busy, 0);
        chk("end.dne_en", rw_op_dne_reg_en, last_done);
        chk("end.done_wr", operation_done_wr, last_done);
        chk("end.error", sts_error, !last_done);
        chk("end.locked", sts_locked, !last_done);
        chk("end.oper_latency", oper_latency, last_done ? sat(len) : 0);
        chk("end.valid", sts_valid, last_done);
        if (last_done) begin
            tick;
            chk("done.idle", sts_idle, 1);
            chk("done.dne_en_once", rw_op_dne_reg_en, 0);
            chk("done.valid_sticky", sts_valid, 1);
        end else begin
            recover_err;
        end
    endtask

    task automatic push(input bit b, input bit l);
        plan_beat.push_back(b);
        plan_last.push_back(l);
    endtask

    start_vec_t vecs[6];

    initial begin
        vecs[0] = '{1, 1, 1, 1, 5, 1};
        vecs[1] = '{1, 1, 1, 0, 5, 0};
        vecs[2] = '{0, 1, 1, 1, 1, 0};
        vecs[3] = '{1, 1, 1, 1, 0, 0};
        vecs[4] = '{1, 0, 1, 1, 7, 0};
        vecs[5] = '{1, 1, 0, 1, 2, 0};

        clear_ins;
        set_loaded(0, 0, 0, 0);
        rslt_size = 0;
        rst = 1;
        tick;
        tick;
        chk("rst.idle", sts_idle, 1);
        chk("rst.reset", sts_reset, 1);
        chk("rst.busy", sts_busy, 0);
        chk("rst.core_start", core_start, 0);
        chk("rst.progress", progress_rslt, 0);
        rst = 0;
        tick;
        chk("rst.reset_rel", sts_reset, 0);
        chk("rst.idle_rel", sts_idle, 1);

        // beats in IDLE must not count
        for (int i = 0; i < 3; i++) begin
            drive_beat(1, 1);
            tick;
            chk("idle.beat_ignored", progress_rslt, 0);
            chk("idle.wo_reg_en", wo_reg_en, 0);
        end
        clear_ins;

        foreach (vecs[i]) begin
            set_loaded(vecs[i].d, vecs[i].g, vecs[i].s, vecs[i].w);
            rslt_size = vecs[i].size;
            operation_start = 1;
            tick;
            operation_start = 0;
            chk("vec.core_start", core_start, vecs[i].exp_start);
            chk("vec.busy", sts_busy, vecs[i].exp_start);
            chk("vec.error", sts_error, !vecs[i].exp_start);
            chk("vec.locked", sts_locked, !vecs[i].exp_start);
            if (vecs[i].exp_start) begin
                interrupt_abort = 1;
                tick;
                chk("vec.abort_idle", sts_idle, 1);
                chk("vec.abort_core_rst", core_rst, 1);
                interrupt_abort = 0;
                tick;
            end else begin
                recover_err;
            end
        end

        // four beats, tlast on beats 2 and 4
        plan_beat = {}; plan_last = {};
        push(1, 0); push(1, 1); push(1, 0); push(1, 1);
        run_plan(4);
        chk("basic.progress_rslt", progress_rslt, 4);
        chk("basic.progress_iter", progress_iter, 2);
        chk("basic.iter_latency", iter_latency, 2);

        // final beat without tlast
        plan_beat = {}; plan_last = {};
        push(1, 0); push(0, 0); push(1, 0); push(1, 0);
        run_plan(3);

        // timers saturate during a long gap
        plan_beat = {}; plan_last = {};
        push(1, 0);
        for (int i = 0; i < 300; i++) push(0, 0);
        push(1, 1);
        run_plan(2);

        // abort after one beat, with a competing beat
        start_op(4);
        drive_beat(1, 0);
        tick;
        drive_beat(1, 1);
        interrupt_abort = 1;
        tick;
        clear_ins;
        chk("abort.idle", sts_idle, 1);
        chk("abort.core_rst", core_rst, 1);
        chk("abort.progress", progress_rslt, 1);
        chk("abort.valid", sts_valid, 0);
        tick;

        // error and abort together with the completing beat
        start_op(2);
        drive_beat(1, 0);
        tick;
        drive_beat(1, 1);
        interrupt_error = 1;
        interrupt_abort = 1;
        tick;
        interrupt_error = 0;
        interrupt_abort = 0;
        rslt_tvalid = 0;
        chk("errab.error", sts_error, 1);
        chk("errab.dne_en", rw_op_dne_reg_en, 0);
        chk("errab.progress", progress_rslt, 1);
        recover_err;

        // abort alone outranks the completing beat
        start_op(1);
        drive_beat(1, 1);
        interrupt_abort = 1;
        tick;
        clear_ins;
        chk("abfin.idle", sts_idle, 1);
        chk("abfin.dne_en", rw_op_dne_reg_en, 0);
        tick;

        // reset mid-RUN
        start_op(6);
        drive_beat(1, 0);
        tick;
        drive_beat(1, 1);
        tick;
        clear_ins;
        rst = 1;
        tick;
        chk("midrst.idle", sts_idle, 1);
        chk("midrst.reset", sts_reset, 1);
        chk("midrst.busy", sts_busy, 0);
        chk("midrst.progress", progress_rslt, 0);
        chk("midrst.iter", progress_iter, 0);
        chk("midrst.oper_timer", oper_timer, 0);
        chk("midrst.iter_latency", iter_latency, 0);
        chk("midrst.wo_reg_en", wo_reg_en, 0);
        rst = 0;
        tick;
        chk("midrst.reset_rel", sts_reset, 0);
        plan_beat = {}; plan_last = {};
        push(1, 1); push(0, 0); push(1, 1);
        run_plan(2);

        // randomized operations
        for (int op = 0; op < 25; op++) begin
            int n;
            n = $urandom_range(1, 6);
            plan_beat = {}; plan_last = {};
            for (int i = 0; i < n; i++) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) push(0, $urandom_range(0, 1));
                if (i == n - 1) push(1, $urandom_range(0, 3) != 0);
                else            push(1, $urandom_range(0, 1));
            end
            run_plan(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
